// File: rtl/seq_detect_param_if.sv
// ============================================================================
// Module : seq_detect_param_if
// Brief  : Bundles the serial-bit, mode and match-report signals of seq_detect_param.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

interface seq_detect_param_if #(
    parameter int CNT_W = 8
);
    logic             i_btn;
    logic             i_valid;
    logic             i_overlap;
    logic             i_clear;
    logic             o_led;
    logic [CNT_W-1:0] o_count;

    modport master (
        output i_btn, i_valid, i_overlap, i_clear,
        input  o_led, o_count
    );

    modport slave (
        input  i_btn, i_valid, i_overlap, i_clear,
        output o_led, o_count
    );
endinterface

`default_nettype wire

// File: rtl/seq_detect_param.sv
// ============================================================================
// Module : seq_detect_param
// Brief  : Parameterised serial pattern detector with overlap mode and a
//          saturating match counter (compiled in by SEQ_DETECT_PARAM_COUNT_EN).
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module seq_detect_param #(
    parameter int                   PATTERN_W = 4,
    parameter logic [PATTERN_W-1:0] PATTERN   = 4'b1010,
    parameter int                   CNT_W     = 8
) (
    input  logic              i_clock,
    input  logic              i_reset_n,
    seq_detect_param_if.slave intf
);
    localparam int                FILL_W   = $clog2(PATTERN_W + 1);
    localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(PATTERN_W);

    logic [PATTERN_W-1:0] r_history;
    logic [FILL_W-1:0]    r_fill;
    logic                 r_led;

    logic [PATTERN_W-1:0] w_history_next;
    logic [FILL_W-1:0]    w_fill_next;
    logic                 w_match;

    always_comb begin
        w_history_next = {r_history[PATTERN_W-2:0], intf.i_btn};
        w_fill_next    = (r_fill == FILL_MAX) ? r_fill : r_fill + FILL_W'(1);
        // The fill check keeps a reset history that happens to equal PATTERN from matching.
        w_match        = intf.i_valid && (w_fill_next == FILL_MAX) &&
                         (w_history_next == PATTERN);
    end

    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_history <= '0;
            r_fill    <= '0;
            r_led     <= 1'b0;
        end else begin
            r_led <= w_match;
            if (intf.i_valid) begin
                if (w_match && !intf.i_overlap) begin
                    r_history <= '0;
                    r_fill    <= '0;
                end else begin
                    r_history <= w_history_next;
                    r_fill    <= w_fill_next;
                end
            end
        end
    end

    assign intf.o_led = r_led;

`ifdef SEQ_DETECT_PARAM_COUNT_EN
    logic [CNT_W-1:0] r_count;

    // Clear has priority over a same-edge match; the count saturates at all-ones.
    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_count <= '0;
        end else if (intf.i_clear) begin
            r_count <= '0;
        end else if (w_match && (r_count != {CNT_W{1'b1}})) begin
            r_count <= r_count + CNT_W'(1);
        end
    end

    assign intf.o_count = r_count;
`else
    logic w_unused_clear;
    assign w_unused_clear = intf.i_clear;
    assign intf.o_count   = '0;
`endif

endmodule

`default_nettype wire

// File: doc/seq_detect_param.md
SEQ_DETECT_PARAM -- requirements
Module: seq_detect_param

Interface
REQ-001 Parameter PATTERN_W, default 4: pattern length in bits, legal range 2..16.
REQ-002 Parameter PATTERN, default 4'b1010: target sequence; MSB is the first bit received.
REQ-003 Parameter CNT_W, default 8: width of the match counter, legal range 1..16.
REQ-004 i_clock  input  1  system clock; all state updates on the rising edge.
REQ-005 i_reset_n  input  1  reset, asynchronous, active-low.
REQ-006 i_btn  input  1  serial data bit.
REQ-007 i_valid  input  1  data qualifier; i_btn is sampled only on an edge where i_valid=1.
REQ-008 i_overlap  input  1  detection mode: 1=overlapping, 0=non-overlapping.
REQ-009 i_clear  input  1  synchronous clear of the match counter.
REQ-010 o_led  output  1  registered match pulse.
REQ-011 o_count  output  CNT_W  number of matches since reset or clear, saturating.

Function
REQ-012 The block SHALL hold a PATTERN_W-bit history shift register and a fill counter (0..PATTERN_W) of valid bits accepted since the last restart.
REQ-013 On an edge with i_valid=1, the block SHALL shift i_btn into the history LSB and increment fill, saturating at PATTERN_W.
REQ-014 On an edge with i_valid=0, history, fill and o_count SHALL hold, and o_led SHALL be 0 in the following cycle.
REQ-015 A match SHALL occur on an accepting edge when the updated fill equals PATTERN_W and the updated history equals PATTERN.
REQ-016 o_led SHALL be 1 for exactly one clock cycle, the cycle that follows the edge producing the match, and 0 otherwise.
REQ-017 Latency from sampling the final pattern bit to o_led high SHALL be one edge, with no combinational path from inputs to o_led.
REQ-018 In overlap mode, after a match fill SHALL remain PATTERN_W, so a suffix of the match can begin the next match.
REQ-019 In non-overlap mode, after a match fill SHALL reset to 0 and history SHALL reset to all-zero.
REQ-020 i_overlap SHALL be evaluated only on the matching edge; changing it between matches SHALL have no other effect.
REQ-021 Each match SHALL increment o_count by 1; at all-ones o_count SHALL hold (saturate) and never wrap.
REQ-022 i_clear=1 SHALL set o_count to 0 on that edge; if a match occurs on the same edge, clear wins (o_count=0) while o_led still pulses.
REQ-023 No match SHALL be reported before PATTERN_W valid bits have been accepted, even if the reset history value equals PATTERN.

Reset
REQ-024 While i_reset_n=0, history=0, fill=0, o_led=0 and o_count=0, applied asynchronously without waiting for a clock edge.
REQ-025 Deassertion of reset mid-sequence SHALL restart detection; no bits accepted before reset contribute to a match.
REQ-026 Reset assertion during an o_led pulse SHALL force o_led to 0 immediately.

Configuration
REQ-027 Macro SEQ_DETECT_PARAM_COUNT_EN: when defined, the match counter, i_clear and the saturation logic are compiled in per REQ-021/022.
REQ-028 Without SEQ_DETECT_PARAM_COUNT_EN, o_count SHALL be tied to 0, i_clear SHALL be ignored, and detection and o_led behaviour SHALL be unchanged.

Verification
REQ-029 Defaults, overlap=1, valid bits 1,0,1,0,1,0 -> o_led pulses after the 4th and 6th bits; o_count=2.
REQ-030 Same stream with overlap=0 -> o_led pulses after the 4th bit only; o_count=1.
REQ-031 Bits 1,0,(valid=0 for 3 cycles),1,0 with overlap=1 -> single o_led pulse after the 4th valid bit; no pulse during the gap cycles.
REQ-032 CNT_W=2 with 5 matches -> o_count reads 1,2,3,3,3; i_clear asserted on the edge of the 6th match -> o_count=0 and o_led=1.
REQ-033 Bits 1,0,1, then i_reset_n low mid-cycle, release, then 0 -> no pulse; following bits 1,0,1,0 -> one pulse and o_count=1.
REQ-034 Build without SEQ_DETECT_PARAM_COUNT_EN, rerun REQ-029 -> identical o_led waveform; o_count=0 throughout.
